// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - single-outstanding AHB-Lite master for core load/store requests
// Optional misalignment trap: define AHB_MASTER_ALIGN_CHK_EN.
module ahb_master (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t state;
    logic   misaligned;
    logic   accept;

`ifdef AHB_MASTER_ALIGN_CHK_EN
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign accept = req_valid && req_ready;
    assign hburst = 3'b000;
    assign hprot  = 4'b0011;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            haddr     <= 32'h0;
            htrans    <= HTRANS_IDLE;
            hwrite    <= 1'b0;
            hsize     <= 3'b010;
            hwdata    <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    // req_ready drops for one cycle after a trapped request
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            haddr  <= req_addr;
                            hwrite <= req_write;
                            hsize  <= {1'b0, req_size};
                            hwdata <= req_wdata;
                            htrans <= HTRANS_NONSEQ;
                            state  <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    // the first ERROR cycle has hready low and is just another wait state
                    if (hready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= hresp;
                        rsp_rdata <= (!hwrite && !hresp) ? hrdata : 32'h0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    htrans    <= HTRANS_IDLE;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// tb/tb_ahb_master.sv - randomized self-checking bench for ahb_master
module tb_ahb_master;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int  tests = 0;
    int  fails = 0;
    time last_accept;

    ahb_master dut (
        .hclk(hclk), .hresetn(hresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Reference: latency = 3 + wait cycles; load data only for error-free reads.
    task automatic run_txn(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                           input logic [31:0] wdat, input int wa, input int wdw,
                           input logic err, input logic [31:0] rd,
                           input logic [2:0] exp_hsize, input bit hold);
        int          lat;
        int          exp_lat;
        logic [31:0] exp_rdata;
        exp_lat   = 3 + wa + wdw;
        exp_rdata = (wr || err) ? 32'h0 : rd;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL req_ready_before: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_addr = a; req_size = sz; req_write = wr; req_wdata = wdat;
        hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
        tick();
        last_accept = $time;
        req_valid = hold; req_addr = $urandom; req_size = 2'($urandom);
        req_write = ~wr; req_wdata = $urandom;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (lat - 1 < wa) begin
                hready = 1'b0; hresp = 1'b0;
            end else if (lat - 1 == wa) begin
                hready = 1'b1; hresp = 1'b0;
            end else if (lat - 1 <= wa + wdw) begin
                hready = 1'b0; hresp = err && (lat - 1 == wa + wdw);
            end else begin
                hready = 1'b1; hresp = err; hrdata = rd;
            end
            if (lat - 1 != wa + wdw + 1) hrdata = $urandom;
            tests++;
            if (htrans !== ((lat - 1 <= wa) ? 2'b10 : 2'b00)) begin
                fails++;
                $display("FAIL htrans_phase: cycle %0d got %b", lat - 1, htrans);
            end
            if (lat - 1 <= wa) begin
                tests++;
                if ({haddr, hsize, hwrite} !== {a, exp_hsize, wr}) begin
                    fails++;
                    $display("FAIL addr_phase: got %h/%b/%b want %h/%b/%b",
                             haddr, hsize, hwrite, a, exp_hsize, wr);
                end
            end
            tests++;
            if (hwdata !== wdat || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL busy_hold: hwdata %h want %h, req_ready %b want 0",
                         hwdata, wdat, req_ready);
            end
            tick();
            lat++;
        end
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL rsp_timeout: rsp_valid %b want 1", rsp_valid);
        end
        tests++;
        if (lat != exp_lat) begin
            fails++;
            $display("FAIL latency: got %0d want %0d", lat, exp_lat);
        end
        tests++;
        if (rsp_err !== err || rsp_rdata !== exp_rdata) begin
            fails++;
            $display("FAIL response: err %b rdata %h want err %b rdata %h",
                     rsp_err, rsp_rdata, err, exp_rdata);
        end
        tests++;
        if (req_ready !== 1'b1 || htrans !== 2'b00) begin
            fails++;
            $display("FAIL rsp_cycle: req_ready %b htrans %b want 1/00", req_ready, htrans);
        end
        hready = 1'b1; hresp = 1'b0;
    endtask

    task automatic check_rsp_drop();
        req_valid = 1'b0;
        tick();
        tests++;
        if (rsp_valid !== 1'b0 || htrans !== 2'b00) begin
            fails++;
            $display("FAIL rsp_one_cycle: rsp_valid %b htrans %b want 0/00", rsp_valid, htrans);
        end
    endtask

    task automatic test_reset();
        hresetn = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hFFFF_FFFF;
        req_size = 2'd0; req_wdata = 32'h5555_5555; hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
        tick(); tick();
        tests++;
        if (htrans !== 2'b00 || haddr !== 32'h0 || hwdata !== 32'h0 || hwrite !== 1'b0 ||
            hsize !== 3'b010 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_bus: htrans %b haddr %h hwdata %h hwrite %b hsize %b req_ready %b",
                     htrans, haddr, hwdata, hwrite, hsize, req_ready);
        end
        tests++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_rsp: %b %b %h", rsp_valid, rsp_err, rsp_rdata);
        end
        tests++;
        if (hburst !== 3'b000 || hprot !== 4'b0011) begin
            fails++;
            $display("FAIL const_outputs: hburst %b hprot %b", hburst, hprot);
        end
        req_valid = 1'b0;
        hresetn = 1'b1;
        tick();
    endtask

    task automatic test_word_read();
        run_txn(32'hA000_0010, 2'd2, 1'b0, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 3'b010, 1'b0);
        check_rsp_drop();
    endtask

    task automatic test_store_waits();
        run_txn(32'hB000_0004, 2'd2, 1'b1, 32'h1234_5678, 2, 3, 1'b0, 32'hCAFE_F00D, 3'b010, 1'b0);
        check_rsp_drop();
    endtask

    task automatic test_error();
        run_txn(32'hB000_0100, 2'd2, 1'b0, 32'h0, 0, 1, 1'b1, 32'h7777_7777, 3'b010, 1'b0);
        check_rsp_drop();
        run_txn(32'hA000_0020, 2'd2, 1'b1, 32'hABCD_0123, 1, 3, 1'b1, 32'h0, 3'b010, 1'b0);
        check_rsp_drop();
    endtask

    task automatic test_back_to_back();
        time t[3];
        for (int i = 0; i < 3; i++) begin
            run_txn(32'hB000_0200 + 32'(i * 4), 2'd2, 1'b0, 32'h0, 0, 0, 1'b0,
                    32'h1000_0000 + 32'(i), 3'b010, i < 2);
            t[i] = last_accept;
        end
        check_rsp_drop();
        tests++;
        if (t[1] - t[0] != 30 || t[2] - t[1] != 30) begin
            fails++;
            $display("FAIL b2b_spacing: got %0t %0t want 30 30", t[1] - t[0], t[2] - t[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          wa;
            int          wdw;
            logic        err;
            sz  = 2'($urandom_range(0, 2));
            a   = {($urandom_range(0, 1) == 0) ? 8'hA0 : 8'hB0, 24'($urandom)};
            a   = a & ~((32'd1 << sz) - 32'd1);
            wa  = $urandom_range(0, 3);
            wdw = $urandom_range(0, 3);
            err = ($urandom_range(0, 3) == 0);
            if (err && wdw == 0) wdw = 1;
            run_txn(a, sz, 1'($urandom), $urandom, wa, wdw, err, $urandom, {1'b0, sz},
                    1'($urandom));
        end
        check_rsp_drop();
    endtask

    task automatic test_misalign();
`ifdef AHB_MASTER_ALIGN_CHK_EN
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hB000_0001; req_size = 2'd1;
        req_wdata = 32'h0; hrdata = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 ||
            req_ready !== 1'b0 || htrans !== 2'b00) begin
            fails++;
            $display("FAIL misalign_trap: v %b e %b d %h rdy %b htrans %b", rsp_valid,
                     rsp_err, rsp_rdata, req_ready, htrans);
        end
        tick();
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || htrans !== 2'b00) begin
            fails++;
            $display("FAIL misalign_after: v %b rdy %b htrans %b", rsp_valid, req_ready, htrans);
        end
        req_valid = 1'b1; req_addr = 32'hA000_0002; req_size = 2'd3;
        tick();
        req_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || htrans !== 2'b00) begin
            fails++;
            $display("FAIL misalign_size3: v %b e %b htrans %b", rsp_valid, rsp_err, htrans);
        end
        tick();
        run_txn(32'hB000_0002, 2'd1, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0000_BEEF, 3'b001, 1'b0);
        check_rsp_drop();
`else
        run_txn(32'hB000_0001, 2'd1, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0000_BEEF, 3'b001, 1'b0);
        check_rsp_drop();
        run_txn(32'hA000_0003, 2'd3, 1'b1, 32'h0102_0304, 1, 0, 1'b0, 32'h0, 3'b011, 1'b0);
        check_rsp_drop();
`endif
    endtask

    task automatic test_reset_mid_data();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hB000_0040; req_size = 2'd0;
        req_wdata = 32'h9999_0000; hready = 1'b1; hresp = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        hready = 1'b0;
        tick();
        #2;
        hresetn = 1'b0;
        #1;
        tests++;
        if (htrans !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
            haddr !== 32'h0 || hwdata !== 32'h0 || hsize !== 3'b010) begin
            fails++;
            $display("FAIL async_reset: htrans %b rsp_valid %b req_ready %b haddr %h hwdata %h hsize %b",
                     htrans, rsp_valid, req_ready, haddr, hwdata, hsize);
        end
        hready = 1'b1;
        tick();
        hresetn = 1'b1;
        tick();
        tests++;
        if (rsp_valid !== 1'b0 || htrans !== 2'b00) begin
            fails++;
            $display("FAIL reset_abandon: rsp_valid %b htrans %b want 0/00", rsp_valid, htrans);
        end
        run_txn(32'hA000_0080, 2'd2, 1'b0, 32'h0, 1, 1, 1'b0, 32'h600D_DA7A, 3'b010, 1'b0);
        check_rsp_drop();
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_store_waits();
        test_error();
        test_back_to_back();
        test_random();
        test_misalign();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_master.md
# ahb_master

Single-outstanding AHB-Lite master that bridges the RISC-V core's load/store request interface onto the system AHB bus. It converts a valid/ready core request into a NONSEQ single transfer, sequences the address and data phases against `hready`, and returns read data and error status to the core. Its `haddr` output feeds the address decoder directly; ROM is selected at `haddr[31:24] == 8'hA0` and every other address goes to RAM.

## Interface
Parameters:
- None; the address and data widths are fixed at 32 bits.

Ports:
- `hclk` in 1: bus clock; all logic is on its rising edge.
- `hresetn` in 1: asynchronous active-low reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: master can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_wdata` in 32: store data, already lane-aligned by the core.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: load data; 0 for stores and errors.
- `rsp_err` out 1: bus error or misalignment; qualified by `rsp_valid`.
- `haddr` out 32, `htrans` out 2, `hwrite` out 1, `hsize` out 3, `hburst` out 3, `hprot` out 4, `hwdata` out 32: AHB master outputs.
- `hrdata` in 32, `hready` in 1, `hresp` in 1: muxed slave response.

## Operation
- **Reset values:** the FSM is in IDLE; `htrans`=2'b00; `haddr`, `hwdata`, `rsp_rdata`=0; `hwrite`, `rsp_valid`, `rsp_err`=0; `hsize`=3'b010; `req_ready`=1.
- **Constant outputs:** `hburst`=3'b000 (SINGLE); `hprot`=4'b0011.
- **FSM states:** IDLE, ADDR, DATA.
- **IDLE:**
  - `req_ready`=1 and `htrans`=IDLE.
  - On `req_valid`, the master registers `haddr`, `hwrite`, `hsize`={1'b0,`req_size`} and `hwdata`, then moves to ADDR.
- **ADDR:**
  - `htrans`=NONSEQ and `req_ready`=0.
  - If `hready`=1 at the edge, the address phase completes and the FSM moves to DATA. Otherwise it stays in ADDR with all address-phase outputs held.
- **DATA:**
  - `htrans`=IDLE.
  - `hwdata` is held until completion.
  - The master waits for `hready`=1.
  - At the completing edge: `rsp_valid`←1, `rsp_err`←`hresp`, and `rsp_rdata`←`hrdata` only when the transfer is a read and `hresp`=0 (else 0). The FSM then returns to IDLE.
- **Two-cycle ERROR response:**
  - The first cycle (`hresp`=1, `hready`=0) is treated as a wait state.
  - Completion happens on the second cycle (`hresp`=1, `hready`=1), with `rsp_err`=1.
  - No further transfer is pending, so no cancellation logic is required.
- **`rsp_valid` duration:** high for exactly one cycle. The core must accept it unconditionally; there is no back-pressure.
- **`haddr`/`hwrite`/`hsize` outside ADDR:** they keep their last values; only `htrans` qualifies them.

## Timing
- Request accepted at edge T0; `htrans`=NONSEQ during T0–T1.
- With zero-wait slaves, `rsp_valid` is high during the cycle after edge T2. The latency from acceptance to response is 3 cycles, plus 1 for each `hready`=0 cycle in ADDR or DATA.
- `req_ready` is high in the same cycle as `rsp_valid`. Back-to-back requests therefore issue every 3 cycles.
- Reset asserted mid-transfer:
  - All outputs immediately (asynchronously) take their reset values, and the FSM goes to IDLE.
  - The in-flight transfer is abandoned and no response is issued.
- `req_*` inputs are sampled only on the accepting edge. Changes afterwards are ignored.

## Configuration
- `AHB_MASTER_ALIGN_CHK_EN`, defined: misaligned requests never reach the bus.
  - A request is misaligned when `req_size`=1 with `req_addr[0]`=1, when `req_size`=2 with `req_addr[1:0]`≠0, or when `req_size`=3.
  - On acceptance of such a request the FSM stays in IDLE and `htrans` stays IDLE.
  - The next cycle gives `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0, which is a 1-cycle latency.
  - `req_ready` is 0 during that response cycle.
- `AHB_MASTER_ALIGN_CHK_EN`, not defined: there is no check. Every request is issued as given, with `hsize`={1'b0,`req_size`}, so `req_size`=3 drives 3'b011.

## Test plan
- **Word read, zero-wait:** read at `req_addr`=32'hA000_0010 with `hrdata`=32'hDEAD_BEEF and `hready` always 1 -> `htrans`=NONSEQ for one cycle with `haddr`=32'hA000_0010 and `hsize`=3'b010; `rsp_valid` 3 cycles after acceptance with `rsp_rdata`=32'hDEAD_BEEF and `rsp_err`=0.
- **Store with wait states:** store of 32'h1234_5678 to 32'hB000_0004 with `hready` low for 2 cycles in ADDR and 3 cycles in DATA -> address-phase outputs held stable in ADDR and `hwdata`=32'h1234_5678 held stable through DATA; `rsp_valid` at latency 8 with `rsp_rdata`=0.
- **Two-cycle error:** read where the slave gives (`hresp`=1, `hready`=0) then (`hresp`=1, `hready`=1) -> a single `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0; `htrans`=IDLE throughout DATA.
- **Back-to-back requests:** `req_valid` held high for 3 requests -> 3 NONSEQ transfers spaced exactly 3 cycles apart, with no gap between each `rsp_valid` and the next acceptance.
- **Misalignment:** half-word at 32'hB000_0001 -> with `AHB_MASTER_ALIGN_CHK_EN`, no NONSEQ and `rsp_err`=1 one cycle later; without the macro, a NONSEQ transfer with `hsize`=3'b001 and `haddr`=32'hB000_0001.
- **Reset mid-DATA:** `hresetn` asserted while in DATA with `hready`=0 -> `htrans`=00, `rsp_valid`=0 and `req_ready`=1 without waiting for a clock edge; after release, a new read completes normally.
